regfile_access_scheduler: RTL
=============================

Name: regfile_access_scheduler

Overview:
- Single-owner sequencer for the 32x32 register file, whose read and write sides are mutually exclusive per cycle.
- Arbitrates between two requesters:
  - the decode stage, which needs an operand read;
  - the writeback stage, which needs an ALU or load-result write.
- Drives reg_read / reg_write as one-cycle pulses with stable address, opcode and data, and signals when latched operands are valid.
- Sits between decode/writeback and the register file.

Parameters:
MAX_WB_BURST, 4, max consecutive granted writes while a non-hazard read waits; then the read is forced.
BURST_W, 3, width of the burst counter; must hold MAX_WB_BURST.

Ports:
clk  input  1  clock; all state updates on posedge
reg_reset  input  1  reset, asynchronous, active-high
rd_valid  input  1  decode requests operand read
rd_ready  output  1  read request accepted this cycle
rd_opcode  input  6  opcode of read instruction
rd_reg1  input  5  source/dest field 1
rd_reg2  input  5  source field 2
rd_reg3  input  5  source field 3
rd_imm  input  32  immediate
rd_done  output  1  one-cycle pulse: register-file operands valid this cycle
wb_valid  input  1  writeback requests register write
wb_ready  output  1  write request accepted this cycle
wb_opcode  input  6  opcode of writing instruction (selects partial write)
wb_reg  input  5  destination register
wb_data  input  32  data to write
reg_read  output  1  to register file
reg_write  output  1  to register file
opcode  output  6  to register file
reg1  output  5  to register file
reg2  output  5  to register file
reg3  output  5  to register file
imm  output  32  to register file
write_data  output  32  to register file
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, WRITE, READ, READ_WAIT. On reg_reset: state=IDLE, burst counter=0, and every output is 0.
- Ready signals:
  - rd_ready and wb_ready are combinational; asserted only in IDLE, and never both in one cycle.
  - A request transfers on a posedge where valid && ready. Request fields are latched into output registers at that edge.
- Arbitration in IDLE, evaluated in order:
  1. If both valid and wb_reg equals rd_reg1, rd_reg2 or rd_reg3 (RAW hazard): grant write. The comparison is conservative over all three fields, independent of opcode.
  2. Else if both valid and burst counter == MAX_WB_BURST: grant read.
  3. Else if wb_valid: grant write.
  4. Else if rd_valid: grant read.
  5. Else stay IDLE.
- Burst counter:
  - Increments on each write grant while rd_valid is high; saturates at MAX_WB_BURST.
  - Clears on any read grant, and in any IDLE cycle where rd_valid is low.
  - A hazard grant increments it but cannot be overridden by it.
- Write grant:
  - Next state WRITE; reg_write=1 for exactly that one cycle.
  - opcode=wb_opcode, reg1=wb_reg, write_data=wb_data; the register file commits at the closing edge.
  - Then IDLE. Write latency from acceptance: 1 cycle.
- Read grant:
  - Next state READ; reg_read=1 for exactly one cycle, with opcode, reg1..reg3 and imm from the rd_* fields.
  - Then READ_WAIT: reg_read=0, rd_done=1 for one cycle, operands valid at the register-file outputs. Then IDLE.
  - Read latency from acceptance to rd_done: 2 cycles.
- reg_read and reg_write are never high together.
- Output fields hold their last latched value in IDLE; reg_read/reg_write are 0 in IDLE.
- Reset mid-operation:
  - Any in-flight WRITE or READ is aborted immediately and reg_read/reg_write drop asynchronously.
  - No rd_done is produced for an aborted read. The requester must re-present.
- Requesters must hold valid and fields stable until accepted. The block does not check this.
- Back-to-back throughput: one write per 2 cycles; one read per 3 cycles.

Test Plan:
- Reset then lone write: wb_valid, wb_reg=5, wb_data=0xDEADBEEF, wb_opcode=0 -> wb_ready in cycle 0; reg_write=1, reg1=5, write_data=0xDEADBEEF in cycle 1; busy=0 in cycle 2.
- Lone read: rd_reg1=1, rd_reg2=2, rd_reg3=3, rd_imm=7, rd_opcode=0x01 -> reg_read=1 in cycle 1; rd_done=1 in cycle 2; reg_write stays 0 throughout.
- Simultaneous, no hazard: wb_reg=9, rd sources 1/2/3, MAX_WB_BURST=4, wb_valid held 6 requests -> 4 writes granted, then the read (rd_done), then the remaining 2 writes; burst counter back to 0 after the read.
- RAW hazard: both valid, wb_reg=2, rd_reg2=2, burst counter forced to 4 -> write granted first; read follows the write in the next IDLE cycle.
- Reset mid-read: assert reg_reset during READ -> reg_read=0 immediately, no rd_done; after release, IDLE with all outputs 0.
- Mutual-exclusion assertion over 10k random valid/field cycles: never reg_read && reg_write, and never rd_ready && wb_ready.

Source files
------------

// File: rtl/regfile_access_scheduler_if.sv
// regfile_access_scheduler_if
//   Bundles the decode-side read request, the writeback-side write request,
//   and the register-file command bus that the scheduler drives.
//   slave  : the scheduler (consumes requests, drives the register file).
//   master : the requester side / environment (drives requests, observes
//            the register-file command bus).
// Signals:
//   rd_valid/rd_ready, rd_opcode, rd_reg1..3, rd_imm, rd_done : operand read
//   wb_valid/wb_ready, wb_opcode, wb_reg, wb_data              : result write
//   reg_read, reg_write, opcode, reg1..3, imm, write_data       : to regfile
//   busy                                                        : not idle
interface regfile_access_scheduler_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [5:0]  rd_opcode;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic [4:0]  rd_reg3;
  logic [31:0] rd_imm;
  logic        rd_done;

  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_opcode;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        reg_read;
  logic        reg_write;
  logic [5:0]  opcode;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic [4:0]  reg3;
  logic [31:0] imm;
  logic [31:0] write_data;
  logic        busy;

  modport slave (
    input  rd_valid, rd_opcode, rd_reg1, rd_reg2, rd_reg3, rd_imm,
    input  wb_valid, wb_opcode, wb_reg, wb_data,
    output rd_ready, rd_done, wb_ready,
    output reg_read, reg_write, opcode, reg1, reg2, reg3, imm, write_data,
    output busy
  );

  modport master (
    output rd_valid, rd_opcode, rd_reg1, rd_reg2, rd_reg3, rd_imm,
    output wb_valid, wb_opcode, wb_reg, wb_data,
    input  rd_ready, rd_done, wb_ready,
    input  reg_read, reg_write, opcode, reg1, reg2, reg3, imm, write_data,
    input  busy
  );
endinterface

// File: rtl/regfile_access_scheduler.sv
// regfile_access_scheduler
//   Single owner of the 32x32 register file. The file can either read or
//   write in a given cycle, so this block arbitrates between the decode
//   stage (operand reads) and the writeback stage (result writes) and
//   issues one-cycle reg_read / reg_write pulses with stable fields.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | accepting at most one request; fields hold last value
//   WRITE     | reg_write pulse, regfile commits at the closing edge
//   READ      | reg_read pulse with opcode/reg1..3/imm
//   READ_WAIT | operands valid at regfile outputs, rd_done pulse
//
// Ports:
//   clk       : clock, all state changes on posedge
//   reg_reset : asynchronous active-high reset
//   bus       : request handshakes and register-file command bus (slave)
//
// Parameters:
//   MAX_WB_BURST : writes granted back-to-back while a non-hazard read waits
//                  before that read is forced through
//   BURST_W      : burst counter width, must be able to hold MAX_WB_BURST
module regfile_access_scheduler #(
  parameter int MAX_WB_BURST = 4,
  parameter int BURST_W      = 3
) (
  input  logic                        clk,
  input  logic                        reg_reset,
  regfile_access_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    READ_WAIT = 2'd3
  } state_t;

  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_WB_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE   = BURST_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic [BURST_W-1:0]   burst_cnt;
  logic [BURST_W-1:0]   burst_nxt;

  logic                 hazard;
  logic                 burst_full;
  logic                 grant_wr;
  logic                 grant_rd;

  // Conservative RAW check: any of the three read fields may be a source,
  // so the pending write goes first whenever its destination matches any.
  always_comb begin
    hazard = bus.rd_valid && bus.wb_valid &&
             ((bus.wb_reg == bus.rd_reg1) ||
              (bus.wb_reg == bus.rd_reg2) ||
              (bus.wb_reg == bus.rd_reg3));
  end

  always_comb begin
    burst_full = (burst_cnt == BURST_LIMIT);
  end

  // Arbitration, only meaningful in IDLE. Reset masks the grants so that the
  // ready outputs read 0 while reg_reset is held.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if ((state == IDLE) && !reg_reset) begin
      if (hazard) begin
        grant_wr = 1'b1;
      end else if (bus.rd_valid && bus.wb_valid && burst_full) begin
        grant_rd = 1'b1;
      end else if (bus.wb_valid) begin
        grant_wr = 1'b1;
      end else if (bus.rd_valid) begin
        grant_rd = 1'b1;
      end
    end
  end

  // Burst counter: counts writes that jumped ahead of a waiting read.
  // A hazard grant still counts, but the hazard check above takes
  // priority over the forced read, so it can never be overridden.
  always_comb begin
    burst_nxt = burst_cnt;
    if (state == IDLE) begin
      if (grant_rd || !bus.rd_valid) begin
        burst_nxt = '0;
      end else if (grant_wr) begin
        burst_nxt = burst_full ? burst_cnt : (burst_cnt + BURST_ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next state and state-decoded outputs. Strobes come straight from the
  // state register so an asynchronous reset drops them immediately.
  always_comb begin
    state_nxt     = state;
    bus.rd_ready  = 1'b0;
    bus.wb_ready  = 1'b0;
    bus.reg_read  = 1'b0;
    bus.reg_write = 1'b0;
    bus.rd_done   = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.busy     = 1'b0;
        bus.wb_ready = grant_wr;
        bus.rd_ready = grant_rd;
        if (grant_wr) begin
          state_nxt = WRITE;
        end else if (grant_rd) begin
          state_nxt = READ;
        end
      end
      WRITE: begin
        bus.reg_write = 1'b1;
        state_nxt     = IDLE;
      end
      READ: begin
        bus.reg_read = 1'b1;
        state_nxt    = READ_WAIT;
      end
      READ_WAIT: begin
        bus.rd_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command fields are captured at the accepting edge and then held, so the
  // register file sees them stable for the whole strobe cycle and beyond.
  // A write leaves reg2/reg3/imm untouched; a read leaves write_data alone.
  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      bus.opcode     <= '0;
      bus.reg1       <= '0;
      bus.reg2       <= '0;
      bus.reg3       <= '0;
      bus.imm        <= '0;
      bus.write_data <= '0;
    end else if (grant_wr) begin
      bus.opcode     <= bus.wb_opcode;
      bus.reg1       <= bus.wb_reg;
      bus.write_data <= bus.wb_data;
    end else if (grant_rd) begin
      bus.opcode <= bus.rd_opcode;
      bus.reg1   <= bus.rd_reg1;
      bus.reg2   <= bus.rd_reg2;
      bus.reg3   <= bus.rd_reg3;
      bus.imm    <= bus.rd_imm;
    end
  end

endmodule
